// File: rtl/cache_mem_bridge.sv
// cache_mem_bridge
//   Memory-side companion to the cache. It turns one held line-wide request
//   into a word-wide Avalon-MM burst:
//     * a fill (c_rd) becomes one read burst of NWORDS beats, reassembled
//       into c_rd_line;
//     * a writeback (c_wr) becomes one write burst of NWORDS beats taken
//       from the latched line.
//   Exactly one request is buffered. The cache holds its request until it
//   sees c_waitrequest low, which happens only in the one-cycle DONE state.
//   A writeback wins over a simultaneous fill; the fill is taken after DONE.
//   Word k of a line (byte address base+4k) sits in the most significant
//   end first: line bits [CLINE_WIDTH-1-k*DATA_WIDTH -: DATA_WIDTH].
//
// Ports
//   clock, reset_n       sole clock, asynchronous active-low reset
//   c_addr               byte address; line offset bits are ignored
//   c_rd / c_wr          fill / writeback request, held until completion
//   c_wr_data            writeback line
//   c_waitrequest        request not yet complete (combinational)
//   c_rd_valid           one-cycle pulse, c_rd_line holds the fill
//   c_rd_line            assembled fill line, kept until the next fill
//   c_error              sticky read-timeout flag
//   avm_*                Avalon-MM burst master, registered outputs
//
// Configuration
//   CACHE_BRIDGE_TIMEOUT_EN  when defined, a watchdog aborts a read that
//                            sees no handshake for TIMEOUT cycles: c_error
//                            is set, missing words read as zero and the
//                            fill completes. When undefined, c_error is 0
//                            and the bridge waits indefinitely.

module cache_mem_bridge #(
  parameter int CLINE_WIDTH = 128,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NWORDS      = CLINE_WIDTH / DATA_WIDTH,
  parameter int BURST_WIDTH = $clog2(NWORDS) + 1,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [ADDR_WIDTH-1:0]  c_addr,
  input  logic                   c_rd,
  input  logic                   c_wr,
  input  logic [CLINE_WIDTH-1:0] c_wr_data,
  output logic                   c_waitrequest,
  output logic                   c_rd_valid,
  output logic [CLINE_WIDTH-1:0] c_rd_line,
  output logic                   c_error,
  output logic [ADDR_WIDTH-1:0]  avm_address,
  output logic [BURST_WIDTH-1:0] avm_burstcount,
  output logic                   avm_read,
  output logic                   avm_write,
  output logic [DATA_WIDTH-1:0]  avm_writedata,
  input  logic [DATA_WIDTH-1:0]  avm_readdata,
  input  logic                   avm_readdatavalid,
  input  logic                   avm_waitrequest
);

  localparam int CNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(NWORDS - 1);
  // Clears the byte-within-line offset so every burst starts line-aligned.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(CLINE_WIDTH / 8 - 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, DONE} state_e;

  // LSB position of word idx inside a line (word 0 at the top).
  function automatic int word_lsb(input logic [CNT_W-1:0] idx);
    return (NWORDS - 1 - int'(idx)) * DATA_WIDTH;
  endfunction

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]       beat_nxt;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [CLINE_WIDTH-1:0] wr_line_q, wr_line_d;
  logic [CLINE_WIDTH-1:0] rd_line_q, rd_line_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   read_q, read_d;
  logic                   write_q, write_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   error_q, error_d;

`ifdef CACHE_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            hs_event;
`endif

  assign beat_nxt = beat_cnt_q + CNT_W'(1);

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    addr_d     = addr_q;
    wr_line_d  = wr_line_q;
    rd_line_d  = rd_line_q;
    wdata_d    = wdata_q;
    read_d     = read_q;
    write_d    = write_q;
    rd_valid_d = 1'b0;
    error_d    = error_q;

    unique case (state_q)
      IDLE: begin
        if (c_wr) begin
          addr_d     = c_addr & LINE_MASK;
          wr_line_d  = c_wr_data;
          beat_cnt_d = '0;
          write_d    = 1'b1;
          wdata_d    = c_wr_data[word_lsb('0) +: DATA_WIDTH];
          state_d    = WR_DATA;
        end else if (c_rd) begin
          addr_d     = c_addr & LINE_MASK;
          beat_cnt_d = '0;
          read_d     = 1'b1;
          state_d    = RD_REQ;
        end
      end
      RD_REQ: begin
        if (!avm_waitrequest) begin
          read_d  = 1'b0;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (avm_readdatavalid) begin
          rd_line_d[word_lsb(beat_cnt_q) +: DATA_WIDTH] = avm_readdata;
          beat_cnt_d = beat_nxt;
          if (beat_cnt_q == LAST_BEAT) begin
            rd_valid_d = 1'b1;
            state_d    = DONE;
          end
        end
      end
      WR_DATA: begin
        // The beat on the bus is accepted only when the interconnect is not
        // stalling; otherwise it is held unchanged.
        if (!avm_waitrequest) begin
          if (beat_cnt_q == LAST_BEAT) begin
            write_d = 1'b0;
            state_d = DONE;
          end else begin
            beat_cnt_d = beat_nxt;
            wdata_d    = wr_line_q[word_lsb(beat_nxt) +: DATA_WIDTH];
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef CACHE_BRIDGE_TIMEOUT_EN
    hs_event = ((state_q == RD_REQ)  && !avm_waitrequest) ||
               ((state_q == RD_DATA) && avm_readdatavalid);
    to_cnt_d = '0;
    if ((state_q == RD_REQ) || (state_q == RD_DATA)) begin
      to_cnt_d = hs_event ? '0 : to_cnt_q + TO_W'(1);
      if (!hs_event && (to_cnt_q == TO_W'(TIMEOUT - 1))) begin
        // Abandon the read: words not yet received read as zero.
        for (int k = 0; k < NWORDS; k++) begin
          if (k >= int'(beat_cnt_q)) begin
            rd_line_d[(NWORDS - 1 - k) * DATA_WIDTH +: DATA_WIDTH] = '0;
          end
        end
        read_d     = 1'b0;
        error_d    = 1'b1;
        rd_valid_d = 1'b1;
        to_cnt_d   = '0;
        state_d    = DONE;
      end
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments only; the blocking
  // assignments above are confined to the combinational next-state block.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the line buffers are plain flops, not a RAM, so they take a
      // defined reset value; an aborted fill must not leave stale words.
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      addr_q     <= '0;
      wr_line_q  <= '0;
      rd_line_q  <= '0;
      wdata_q    <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      addr_q     <= addr_d;
      wr_line_q  <= wr_line_d;
      rd_line_q  <= rd_line_d;
      wdata_q    <= wdata_d;
      read_q     <= read_d;
      write_q    <= write_d;
      rd_valid_q <= rd_valid_d;
      error_q    <= error_d;
    end
  end

`ifdef CACHE_BRIDGE_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) to_cnt_q <= '0;
    else          to_cnt_q <= to_cnt_d;
  end
`endif

  assign c_waitrequest  = (c_rd | c_wr) & (state_q != DONE);
  assign c_rd_valid     = rd_valid_q;
  assign c_rd_line      = rd_line_q;
  assign c_error        = error_q;
  assign avm_address    = addr_q;
  assign avm_burstcount = BURST_WIDTH'(NWORDS);
  assign avm_read       = read_q;
  assign avm_write      = write_q;
  assign avm_writedata  = wdata_q;

endmodule
